// File: rtl/dma_xfer_ctrl.sv
// Single-channel DMA transfer sequencer: CPU programming, bus handshake, read/write word cycles.
// Optional external end-of-process input is enabled by defining DMA_EXT_EOP_EN.
module dma_xfer_ctrl #(
  parameter int AW = 8,
  parameter int DW = 8,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cs,
  input  logic          DB_wrReq,
  input  logic [DW-1:0] DB,
  input  logic [CW-1:0] wordcount,
  input  logic          IORead,
  input  logic          MemToMem,
  input  logic          HACK,
`ifdef DMA_EXT_EOP_EN
  input  logic          eop_in,
`endif
  output logic          HREQ,
  output logic [AW-1:0] addr,
  output logic          mem_rd,
  output logic          mem_wr,
  output logic          io_rd,
  output logic          io_wr,
  input  logic [DW-1:0] rd_data,
  output logic [DW-1:0] wr_data,
  output logic          EOP,
  output logic          busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PROG2,
    S_REQ,
    S_READ,
    S_WRITE,
    S_DONE
  } state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] src_addr, dst_addr;
  logic [CW-1:0] cnt;
  logic          mode_m2m, mode_ior;
  logic [DW-1:0] tmp;
  logic          prog_wr;
  logic          ext_eop;
  logic          rd_fire;

`ifdef DMA_EXT_EOP_EN
  assign ext_eop = eop_in;
`else
  assign ext_eop = 1'b0;
`endif

  assign prog_wr = cs & DB_wrReq;
  // A read cycle only strobes when the bus is still granted and no early stop is requested.
  assign rd_fire = (state == S_READ) & HACK & ~ext_eop;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (prog_wr) state_nxt = S_PROG2;
      S_PROG2: begin
        if (prog_wr)  state_nxt = (cnt == '0) ? S_DONE : S_REQ;
        else if (!cs) state_nxt = S_IDLE;
      end
      S_REQ: begin
        if (ext_eop)   state_nxt = S_DONE;
        else if (HACK) state_nxt = S_READ;
      end
      S_READ: begin
        if (ext_eop)    state_nxt = S_DONE;
        else if (!HACK) state_nxt = S_REQ;
        else            state_nxt = S_WRITE;
      end
      S_WRITE: state_nxt = ((cnt == CW'(1)) || ext_eop) ? S_DONE : S_READ;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      src_addr <= '0;
      dst_addr <= '0;
      cnt      <= '0;
      mode_m2m <= 1'b0;
      mode_ior <= 1'b0;
      tmp      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (prog_wr) begin
            src_addr <= AW'(DB);
            cnt      <= wordcount;
            mode_m2m <= MemToMem;
            mode_ior <= IORead;
          end
        end
        S_PROG2: if (prog_wr) dst_addr <= AW'(DB);
        S_READ:  if (rd_fire) tmp <= rd_data;
        S_WRITE: begin
          // The memory-side address always advances; the IO address stays put unless both sides are memory.
          cnt      <= cnt - CW'(1);
          src_addr <= src_addr + AW'(1);
          if (mode_m2m) dst_addr <= dst_addr + AW'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    HREQ    = 1'b0;
    addr    = '0;
    mem_rd  = 1'b0;
    mem_wr  = 1'b0;
    io_rd   = 1'b0;
    io_wr   = 1'b0;
    wr_data = '0;
    EOP     = 1'b0;
    busy    = (state != S_IDLE);
    case (state)
      S_REQ: HREQ = 1'b1;
      S_READ: begin
        HREQ = 1'b1;
        if (mode_ior && !mode_m2m) begin
          addr  = dst_addr;
          io_rd = rd_fire;
        end else begin
          addr   = src_addr;
          mem_rd = rd_fire;
        end
      end
      S_WRITE: begin
        HREQ    = 1'b1;
        wr_data = tmp;
        if (mode_m2m) begin
          addr   = dst_addr;
          mem_wr = 1'b1;
        end else if (mode_ior) begin
          addr   = src_addr;
          mem_wr = 1'b1;
        end else begin
          addr  = dst_addr;
          io_wr = 1'b1;
        end
      end
      S_DONE: EOP = 1'b1;
      default: ;
    endcase
  end

endmodule
